// File: rtl/satswarm_host_ctrl.sv
// Host-side control for SatSwarm: CNF load buffer with masked broadcast, start/abort sequencing,
// run-cycle counter with timeout, and sticky first-winner result capture. Optional: SATSWARM_LOAD_STATS_EN.
module satswarm_host_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int LIT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CYC_W      = 48,
  parameter int WIN_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_start,
  input  logic                 host_abort,
  input  logic [CYC_W-1:0]     host_timeout_cycles,
  input  logic [NUM_CORES-1:0] core_enable_mask,
  input  logic                 host_load_valid,
  input  logic [LIT_W-1:0]     host_load_literal,
  input  logic                 host_load_clause_end,
  output logic                 host_load_ready,
  output logic                 core_load_valid,
  output logic [LIT_W-1:0]     core_load_literal,
  output logic                 core_load_clause_end,
  input  logic [NUM_CORES-1:0] core_load_ready,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NUM_CORES-1:0] core_abort,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_sat,
  input  logic [NUM_CORES-1:0] core_unsat,
  output logic                 host_busy,
  output logic                 host_done,
  output logic                 host_sat,
  output logic                 host_unsat,
  output logic                 host_timeout,
  output logic                 host_conflict,
  output logic [WIN_W-1:0]     host_winner,
  output logic [CYC_W-1:0]     host_cycles,
  output logic [31:0]          host_lit_count,
  output logic [31:0]          host_clause_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRAIN = 2'd1, ST_RUN = 2'd2, ST_DONE = 2'd3} state_t;

  state_t                 state_r;
  logic                   pending_start_r;
  logic [LIT_W-1:0]       fifo_lit_r [FIFO_DEPTH];
  logic                   fifo_ce_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   push_s, pop_s, full_s, empty_s;
  logic [NUM_CORES-1:0]   core_start_r, core_abort_r;
  logic                   sat_r, unsat_r, timeout_r, conflict_r;
  logic [WIN_W-1:0]       winner_r;
  logic [CYC_W-1:0]       cycles_r;
  logic [NUM_CORES-1:0]   done_en_s, win_oh_s, other_s;
  logic [WIN_W-1:0]       win_idx_s;
  logic                   found_s, any_done_s, win_sat_s, win_unsat_s, conflict_s, timeout_hit_s;

  assign full_s          = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s         = (count_r == {CNT_W{1'b0}});
  assign host_load_ready = !full_s && (state_r == ST_IDLE) && !pending_start_r;
  assign push_s          = host_load_valid && host_load_ready;
  // Disabled cores never hold back the broadcast.
  assign pop_s           = !empty_s && (&(core_load_ready | ~core_enable_mask));

  assign core_load_valid      = !empty_s;
  assign core_load_literal    = fifo_lit_r[rd_ptr_r];
  assign core_load_clause_end = fifo_ce_r[rd_ptr_r];

  // Load buffer storage, pointers and occupancy; abort flushes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_lit_r[i] <= '0;
        fifo_ce_r[i]  <= 1'b0;
      end
    end else if (host_abort) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_lit_r[wr_ptr_r] <= host_load_literal;
        fifo_ce_r[wr_ptr_r]  <= host_load_clause_end;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Winner selection: lowest enabled done core, plus disagreement among the other finishers.
  always_comb begin
    done_en_s = core_done & core_enable_mask;
    win_idx_s = '0;
    win_oh_s  = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (done_en_s[i] && !found_s) begin
        win_idx_s   = WIN_W'(i);
        win_oh_s[i] = 1'b1;
        found_s     = 1'b1;
      end else begin
        win_oh_s[i] = 1'b0;
      end
    end
    any_done_s    = |done_en_s;
    win_sat_s     = |(core_sat & win_oh_s);
    win_unsat_s   = |(core_unsat & win_oh_s);
    other_s       = done_en_s & ~win_oh_s;
    conflict_s    = (win_sat_s && (|(other_s & core_unsat))) ||
                    (win_unsat_s && (|(other_s & core_sat)));
    timeout_hit_s = (host_timeout_cycles != {CYC_W{1'b0}}) &&
                    (cycles_r == host_timeout_cycles - CYC_W'(1));
  end

  // Control FSM with registered start/abort pulses and sticky results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      pending_start_r <= 1'b0;
      core_start_r    <= '0;
      core_abort_r    <= '0;
      sat_r           <= 1'b0;
      unsat_r         <= 1'b0;
      timeout_r       <= 1'b0;
      conflict_r      <= 1'b0;
      winner_r        <= '0;
      cycles_r        <= '0;
    end else begin
      core_start_r <= '0;
      core_abort_r <= '0;
      if (host_abort) begin
        state_r         <= ST_IDLE;
        pending_start_r <= 1'b0;
        core_abort_r    <= core_enable_mask;
        sat_r           <= 1'b0;
        unsat_r         <= 1'b0;
        timeout_r       <= 1'b0;
        conflict_r      <= 1'b0;
        winner_r        <= '0;
        cycles_r        <= '0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DRAIN, ST_DONE: begin
            if ((state_r == ST_DRAIN && empty_s) ||
                (state_r != ST_DRAIN && host_start && (empty_s || state_r == ST_DONE))) begin
              state_r         <= ST_RUN;
              pending_start_r <= 1'b0;
              core_start_r    <= core_enable_mask;
              cycles_r        <= '0;
              sat_r           <= 1'b0;
              unsat_r         <= 1'b0;
              timeout_r       <= 1'b0;
              conflict_r      <= 1'b0;
              winner_r        <= '0;
            end else if (state_r == ST_IDLE && host_start) begin
              state_r         <= ST_DRAIN;
              pending_start_r <= 1'b1;
            end else begin
              state_r <= state_r;
            end
          end
          ST_RUN: begin
            if (cycles_r != {CYC_W{1'b1}}) begin
              cycles_r <= cycles_r + CYC_W'(1);
            end else begin
              cycles_r <= cycles_r;
            end
            if (any_done_s) begin
              state_r      <= ST_DONE;
              winner_r     <= win_idx_s;
              sat_r        <= win_sat_s;
              unsat_r      <= win_unsat_s;
              conflict_r   <= conflict_s;
              timeout_r    <= 1'b0;
              core_abort_r <= core_enable_mask;
            end else if (timeout_hit_s) begin
              state_r      <= ST_DONE;
              timeout_r    <= 1'b1;
              sat_r        <= 1'b0;
              unsat_r      <= 1'b0;
              core_abort_r <= core_enable_mask;
            end else begin
              state_r <= ST_RUN;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign core_start    = core_start_r;
  assign core_abort    = core_abort_r;
  assign host_busy     = (state_r == ST_RUN);
  assign host_done     = (state_r == ST_DONE);
  assign host_sat      = sat_r;
  assign host_unsat    = unsat_r;
  assign host_timeout  = timeout_r;
  assign host_conflict = conflict_r;
  assign host_winner   = winner_r;
  assign host_cycles   = cycles_r;

`ifdef SATSWARM_LOAD_STATS_EN
  logic [31:0] lit_cnt_r, cls_cnt_r;

  // Load statistics over accepted pushes; zero literals are clause padding and not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lit_cnt_r <= 32'd0;
      cls_cnt_r <= 32'd0;
    end else if (host_abort) begin
      lit_cnt_r <= 32'd0;
      cls_cnt_r <= 32'd0;
    end else begin
      if (push_s && (host_load_literal != {LIT_W{1'b0}})) lit_cnt_r <= lit_cnt_r + 32'd1;
      if (push_s && host_load_clause_end) cls_cnt_r <= cls_cnt_r + 32'd1;
    end
  end

  assign host_lit_count    = lit_cnt_r;
  assign host_clause_count = cls_cnt_r;
`else
  assign host_lit_count    = 32'd0;
  assign host_clause_count = 32'd0;
`endif

endmodule

// File: tb/tb_satswarm_host_ctrl.sv
// Directed bench for satswarm_host_ctrl: load/broadcast, backpressure, drain-start, winner/conflict, timeout, abort.
module tb_satswarm_host_ctrl;
  localparam int NC = 4;
  localparam int LW = 32;
  localparam int FD = 4;
  localparam int CW = 48;
  localparam int WW = 2;
`ifdef SATSWARM_LOAD_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic clk, rst, host_start, host_abort;
  logic [CW-1:0] host_timeout_cycles;
  logic [NC-1:0] core_enable_mask, core_load_ready, core_start, core_abort, core_done, core_sat, core_unsat;
  logic host_load_valid, host_load_clause_end, host_load_ready;
  logic [LW-1:0] host_load_literal, core_load_literal;
  logic core_load_valid, core_load_clause_end;
  logic host_busy, host_done, host_sat, host_unsat, host_timeout, host_conflict;
  logic [WW-1:0] host_winner;
  logic [CW-1:0] host_cycles;
  logic [31:0] host_lit_count, host_clause_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [LW-1:0] lit_tab [7];
  logic          ce_tab  [7];

  satswarm_host_ctrl #(.NUM_CORES(NC), .LIT_W(LW), .FIFO_DEPTH(FD), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .host_start(host_start), .host_abort(host_abort),
    .host_timeout_cycles(host_timeout_cycles), .core_enable_mask(core_enable_mask),
    .host_load_valid(host_load_valid), .host_load_literal(host_load_literal),
    .host_load_clause_end(host_load_clause_end), .host_load_ready(host_load_ready),
    .core_load_valid(core_load_valid), .core_load_literal(core_load_literal),
    .core_load_clause_end(core_load_clause_end), .core_load_ready(core_load_ready),
    .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
    .core_sat(core_sat), .core_unsat(core_unsat), .host_busy(host_busy),
    .host_done(host_done), .host_sat(host_sat), .host_unsat(host_unsat),
    .host_timeout(host_timeout), .host_conflict(host_conflict), .host_winner(host_winner),
    .host_cycles(host_cycles), .host_lit_count(host_lit_count), .host_clause_count(host_clause_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_two;
    host_load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      host_load_literal = lit_tab[i];
      host_load_clause_end = ce_tab[i];
      tick();
    end
    host_load_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (host_load_ready !== 1'b1 || core_load_valid !== 1'b0 || host_busy !== 1'b0 || host_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: ready=%b valid=%b busy=%b done=%b, expected 1 0 0 0",
               host_load_ready, core_load_valid, host_busy, host_done);
    end
    vec_cnt++;
    if (core_start !== 4'b0000 || core_abort !== 4'b0000 || host_cycles !== 48'd0 ||
        host_winner !== 2'd0 || host_lit_count !== 32'd0 || host_sat !== 1'b0 || host_timeout !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_values: start=%b abort=%b cycles=%0d winner=%0d lits=%0d sat=%b to=%b, expected all 0",
               core_start, core_abort, host_cycles, host_winner, host_lit_count, host_sat, host_timeout);
    end
    rst = 1'b0;
    tick();
  endtask

  // Streams the 7-literal table; core 1 stalled for `stall` cycles, core 2 never ready (disabled).
  task automatic test_stream(input int stall, input int exp_lits, input int exp_cls);
    int pushed, popped, first_block, cyc;
    pushed = 0; popped = 0; first_block = -1; cyc = 0;
    while (popped < 7 && cyc < 80) begin
      host_load_valid = (pushed < 7);
      if (pushed < 7) begin
        host_load_literal = lit_tab[pushed];
        host_load_clause_end = ce_tab[pushed];
      end
      core_load_ready = (cyc < stall) ? 4'b1001 : 4'b1011;
      if (host_load_valid && host_load_ready) pushed++;
      else if (host_load_valid && first_block < 0) first_block = pushed;
      if (core_load_valid && (&(core_load_ready | ~core_enable_mask))) begin
        vec_cnt++;
        if (core_load_literal !== lit_tab[popped] || core_load_clause_end !== ce_tab[popped]) begin
          err_cnt++;
          $display("FAIL bcast_data[%0d]: got %0h/%b, expected %0h/%b", popped,
                   core_load_literal, core_load_clause_end, lit_tab[popped], ce_tab[popped]);
        end
        popped++;
      end
      tick();
      cyc++;
    end
    host_load_valid = 1'b0;
    vec_cnt++;
    if (popped != 7 || core_load_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL bcast_count: got %0d pops (valid after=%b), expected 7 (0)", popped, core_load_valid);
    end
    if (stall > 0) begin
      vec_cnt++;
      if (first_block != FD) begin
        err_cnt++;
        $display("FAIL full_backpressure: ready dropped after %0d pushes, expected %0d", first_block, FD);
      end
    end
    vec_cnt++;
    if (host_lit_count !== 32'(exp_lits * STATS_ON) || host_clause_count !== 32'(exp_cls * STATS_ON)) begin
      err_cnt++;
      $display("FAIL load_stats: got lits=%0d clauses=%0d, expected %0d %0d", host_lit_count,
               host_clause_count, exp_lits * STATS_ON, exp_cls * STATS_ON);
    end
  endtask

  task automatic test_drain_start;
    int n;
    core_load_ready = 4'b0000;
    push_two();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    vec_cnt++;
    if (host_load_ready !== 1'b0 || host_busy !== 1'b0 || core_start !== 4'b0000 || core_load_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL drain_enter: ready=%b busy=%b start=%b valid=%b, expected 0 0 0000 1",
               host_load_ready, host_busy, core_start, core_load_valid);
    end
    core_load_ready = 4'b1011;
    n = 0;
    while (core_load_valid && n < 10) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n != 2 || core_start !== 4'b0000) begin
      err_cnt++;
      $display("FAIL drain_pops: got %0d pops start=%b, expected 2 0000", n, core_start);
    end
    tick();
    vec_cnt++;
    if (core_start !== 4'b1011 || host_busy !== 1'b1 || host_cycles !== 48'd0) begin
      err_cnt++;
      $display("FAIL drain_start_pulse: start=%b busy=%b cycles=%0d, expected 1011 1 0",
               core_start, host_busy, host_cycles);
    end
    tick();
    vec_cnt++;
    if (core_start !== 4'b0000 || host_cycles !== 48'd1) begin
      err_cnt++;
      $display("FAIL start_one_cycle: start=%b cycles=%0d, expected 0000 1", core_start, host_cycles);
    end
  endtask

  task automatic test_done_conflict;
    core_done = 4'b0100; core_sat = 4'b0100;
    tick();
    vec_cnt++;
    if (host_busy !== 1'b1 || host_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL disabled_done: busy=%b done=%b, expected 1 0", host_busy, host_done);
    end
    core_done = 4'b1010; core_sat = 4'b1000; core_unsat = 4'b0010;
    tick();
    core_done = 4'b0000; core_sat = 4'b0000; core_unsat = 4'b0000;
    vec_cnt++;
    if (host_done !== 1'b1 || host_busy !== 1'b0 || host_winner !== 2'd1 || host_unsat !== 1'b1 ||
        host_sat !== 1'b0 || host_conflict !== 1'b1 || host_timeout !== 1'b0 || core_abort !== 4'b1011) begin
      err_cnt++;
      $display("FAIL winner_conflict: done=%b busy=%b win=%0d unsat=%b sat=%b conf=%b to=%b abort=%b, expected 1 0 1 1 0 1 0 1011",
               host_done, host_busy, host_winner, host_unsat, host_sat, host_conflict, host_timeout, core_abort);
    end
    tick();
    vec_cnt++;
    if (core_abort !== 4'b0000 || host_done !== 1'b1 || host_winner !== 2'd1 || host_cycles !== 48'd3) begin
      err_cnt++;
      $display("FAIL results_hold: abort=%b done=%b win=%0d cycles=%0d, expected 0000 1 1 3",
               core_abort, host_done, host_winner, host_cycles);
    end
  endtask

  task automatic test_timeout;
    int n;
    host_timeout_cycles = 48'd100;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    vec_cnt++;
    if (host_busy !== 1'b1 || host_done !== 1'b0 || host_unsat !== 1'b0 || host_conflict !== 1'b0 ||
        core_start !== 4'b1011 || host_cycles !== 48'd0) begin
      err_cnt++;
      $display("FAIL restart_clears: busy=%b done=%b unsat=%b conf=%b start=%b cycles=%0d, expected 1 0 0 0 1011 0",
               host_busy, host_done, host_unsat, host_conflict, core_start, host_cycles);
    end
    n = 0;
    while (!host_done && n < 200) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (n != 100 || host_cycles !== 48'd100 || host_timeout !== 1'b1 || host_sat !== 1'b0 ||
        host_unsat !== 1'b0 || core_abort !== 4'b1011) begin
      err_cnt++;
      $display("FAIL timeout: ticks=%0d cycles=%0d to=%b sat=%b unsat=%b abort=%b, expected 100 100 1 0 0 1011",
               n, host_cycles, host_timeout, host_sat, host_unsat, core_abort);
    end
    host_timeout_cycles = 48'd3;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    vec_cnt++;
    if (host_timeout !== 1'b0 || host_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL restart_timeout_clear: to=%b busy=%b, expected 0 1", host_timeout, host_busy);
    end
    tick();
    tick();
    core_done = 4'b0001; core_sat = 4'b0001;
    tick();
    core_done = 4'b0000; core_sat = 4'b0000;
    vec_cnt++;
    if (host_done !== 1'b1 || host_timeout !== 1'b0 || host_sat !== 1'b1 || host_winner !== 2'd0 ||
        host_conflict !== 1'b0 || host_cycles !== 48'd3) begin
      err_cnt++;
      $display("FAIL done_beats_timeout: done=%b to=%b sat=%b win=%0d conf=%b cycles=%0d, expected 1 0 1 0 0 3",
               host_done, host_timeout, host_sat, host_winner, host_conflict, host_cycles);
    end
    host_timeout_cycles = 48'd0;
  endtask

  task automatic test_abort_drain;
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    vec_cnt++;
    if (host_load_ready !== 1'b1 || host_done !== 1'b0 || host_sat !== 1'b0 || core_abort !== 4'b1011 ||
        host_cycles !== 48'd0 || host_lit_count !== 32'd0) begin
      err_cnt++;
      $display("FAIL abort_done: ready=%b done=%b sat=%b abort=%b cycles=%0d lits=%0d, expected 1 0 0 1011 0 0",
               host_load_ready, host_done, host_sat, core_abort, host_cycles, host_lit_count);
    end
    core_load_ready = 4'b0000;
    push_two();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    vec_cnt++;
    if (core_load_valid !== 1'b0 || host_load_ready !== 1'b1 || host_busy !== 1'b0 ||
        core_abort !== 4'b1011 || core_start !== 4'b0000 || host_clause_count !== 32'd0) begin
      err_cnt++;
      $display("FAIL abort_drain: valid=%b ready=%b busy=%b abort=%b start=%b cls=%0d, expected 0 1 0 1011 0000 0",
               core_load_valid, host_load_ready, host_busy, core_abort, core_start, host_clause_count);
    end
    core_load_ready = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (core_start !== 4'b0000 || host_busy !== 1'b0 || core_abort !== 4'b0000) begin
        err_cnt++;
        $display("FAIL abort_no_start[%0d]: start=%b busy=%b abort=%b, expected 0000 0 0000",
                 i, core_start, host_busy, core_abort);
      end
    end
  endtask

  initial begin
    lit_tab[0] = 32'd5;  lit_tab[1] = -32'sd3; lit_tab[2] = 32'd7;  lit_tab[3] = 32'd2;
    lit_tab[4] = -32'sd9; lit_tab[5] = 32'd11; lit_tab[6] = -32'sd4;
    ce_tab[0] = 1'b0; ce_tab[1] = 1'b0; ce_tab[2] = 1'b1; ce_tab[3] = 1'b0;
    ce_tab[4] = 1'b1; ce_tab[5] = 1'b0; ce_tab[6] = 1'b1;
    host_start = 1'b0; host_abort = 1'b0; host_timeout_cycles = 48'd0;
    core_enable_mask = 4'b1011; core_load_ready = 4'b0000;
    host_load_valid = 1'b0; host_load_literal = 32'd0; host_load_clause_end = 1'b0;
    core_done = 4'b0000; core_sat = 4'b0000; core_unsat = 4'b0000;
    test_reset();
    test_stream(0, 7, 3);
    test_stream(10, 14, 6);
    test_drain_start();
    test_done_conflict();
    test_timeout();
    test_abort_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
